// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a 256 x 8 register file, PREADY stretched by WAIT_STATES.
// Latency: setup in cycle T, PREADY high in T+1+WAIT_STATES, transfer takes 2+WAIT_STATES cycles.
// Backpressure: PREADY is held low for WAIT_STATES access cycles; PSEL low in ACCESS aborts with no write.
//
// Ports:
//   PCLK, PRESETn        clock (rising edge), asynchronous active-low reset
//   PSEL, PENABLE        APB select / access-phase strobe
//   PWRITE, PADDR[8:0]   direction and address (PADDR[8] decoded upstream, ignored here)
//   PWDATA[7:0]          write data
//   PRDATA[7:0]          registered read data, holds outside read completions
//   PREADY               registered, one-cycle pulse per completed transfer
//   PSLVERR              registered error flag, meaningful only while PREADY=1
//
// Optional feature: define APB_SLV_PSLVERR_EN to make addresses >= RO_BASE read-only;
// writes there complete with PSLVERR=1 and leave memory untouched. Without it PSLVERR
// stays 0 and all 256 entries are writable.

module apb_slave_mem #(
  parameter int         WAIT_STATES = 0,      // 0..7
  parameter logic [7:0] RO_BASE     = 8'hF0
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [8:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

`ifdef APB_SLV_PSLVERR_EN
  localparam logic RO_EN = 1'b1;
`else
  localparam logic RO_EN = 1'b0;
`endif

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state, state_nxt;
  logic [7:0] mem [256];
  logic [7:0] addr_q, wdata_q;
  logic       wr_q;
  logic [2:0] cnt;

  logic [7:0] prdata_nxt;
  logic       pready_nxt, pslverr_nxt;
  logic [2:0] cnt_nxt;
  logic       latch_req;
  logic       mem_we;

  logic       setup_ph;
  logic       unused_paddr_msb;

  assign setup_ph         = PSEL & ~PENABLE;
  assign unused_paddr_msb = PADDR[8];

  // Constant-folds to 0 when the read-only region is not compiled in.
  function automatic logic ro_hit(input logic [7:0] a);
    return RO_EN && (a >= RO_BASE);
  endfunction

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (setup_ph) state_nxt = ACCESS;
      ACCESS: if (!PSEL || (PENABLE && PREADY)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next-value logic; all outputs are registered below.
  always_comb begin
    prdata_nxt  = PRDATA;
    pready_nxt  = PREADY;
    pslverr_nxt = PSLVERR;
    cnt_nxt     = cnt;
    latch_req   = 1'b0;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        // PENABLE=1 without a preceding setup phase falls through and is ignored.
        if (setup_ph) begin
          latch_req   = 1'b1;
          cnt_nxt     = WS;
          pready_nxt  = (WS == 3'd0);
          pslverr_nxt = (WS == 3'd0) && PWRITE && ro_hit(PADDR[7:0]);
          if ((WS == 3'd0) && !PWRITE) prdata_nxt = mem[PADDR[7:0]];
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Abort: drop any pending response, PRDATA keeps its old value.
          pready_nxt  = 1'b0;
          pslverr_nxt = 1'b0;
        end else if (PENABLE) begin
          if (PREADY) begin
            mem_we      = wr_q && !ro_hit(addr_q);
            pready_nxt  = 1'b0;
            pslverr_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt - 3'd1;
            if (cnt == 3'd1) begin
              pready_nxt  = 1'b1;
              pslverr_nxt = wr_q && ro_hit(addr_q);
              if (!wr_q) prdata_nxt = mem[addr_q];
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs, latched request and storage
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PRDATA  <= 8'h00;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      cnt     <= 3'd0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      wr_q    <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else begin
      PRDATA  <= prdata_nxt;
      PREADY  <= pready_nxt;
      PSLVERR <= pslverr_nxt;
      cnt     <= cnt_nxt;
      if (latch_req) begin
        addr_q  <= PADDR[7:0];
        wdata_q <= PWDATA;
        wr_q    <= PWRITE;
      end
      // Commit uses the latched address/data, so bus changes during ACCESS are harmless.
      if (mem_we) mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB slave target: 256 x 8 register-file memory with a programmable wait-state counter. Sits directly downstream of the APB master bridge. Two instances are placed, one on PSEL1 and one on PSEL2; each drives PRDATA/PREADY back to the bridge through the system mux. It gives the bridge a cycle-accurate completer with parameterised PREADY stretching and optional PSLVERR generation.

## Interface
- WAIT_STATES, 0, access-phase wait cycles inserted before PREADY; legal range 0..7.
- RO_BASE, 8'hF0, first address of the read-only region; used only when APB_SLV_PSLVERR_EN is defined.
- PCLK  input  1  clock; all state updates on rising edge.
- PRESETn  input  1  reset; asynchronous assert, active-low.
- PSEL  input  1  slave select (PSEL1 or PSEL2 from the bridge).
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  9  address; bit 8 is ignored (decoded upstream), bits 7:0 index memory.
- PWDATA  input  8  write data.
- PRDATA  output  8  read data, registered.
- PREADY  output  1  transfer-complete indicator, registered.
- PSLVERR  output  1  error response, registered, valid only while PREADY=1.

## Operation
- Storage: mem[0..255], 8 bits each. All entries cleared to 8'h00 on reset.
- FSM has two states.
  - IDLE: waits for a setup phase (PSEL=1, PENABLE=0). At that edge:
    - latch addr=PADDR[7:0], wr=PWRITE, wdata=PWDATA;
    - load cnt=WAIT_STATES;
    - PREADY<=(WAIT_STATES==0);
    - if WAIT_STATES==0 and the transfer is a read, PRDATA<=mem[PADDR[7:0]];
    - go to ACCESS.
  - ACCESS, while PREADY=0 and PSEL=PENABLE=1: cnt<=cnt-1. When cnt==1, PREADY<=1 and a read loads PRDATA<=mem[addr].
  - ACCESS, completion edge (PSEL=PENABLE=PREADY=1):
    - a write commits mem[addr]<=wdata, unless blocked by the error rule;
    - PREADY<=0, PSLVERR<=0, go to IDLE.
- Back-to-back transfers: the bridge's ENABLE->SETUP cycle arrives while the slave is in IDLE and is accepted normally.
- Abort: PSEL=0 in ACCESS before completion -> IDLE, PREADY<=0, no memory write, PRDATA holds.
- PENABLE=1 while PSEL=1 in IDLE (missing setup phase) is ignored. The slave stays in IDLE and PREADY stays 0.
- PRDATA holds its last value outside read completions. Writes never change PRDATA.
- Latched addr/wdata are used for the commit. PADDR/PWDATA changes during ACCESS have no effect.

## Timing
- Reset values: PRDATA=8'h00, PREADY=0, PSLVERR=0, state=IDLE, cnt=0, memory all zero. Reset mid-transfer aborts immediately with no write.
- Setup phase in cycle T. PREADY is high in cycle T+1+WAIT_STATES. The transfer completes at the end of that cycle.
- Total APB transfer: 2+WAIT_STATES cycles.
- Read data is valid in the same cycle PREADY is high.
- A write is visible to a read whose setup phase starts in the cycle after completion.
- PREADY is high for exactly one cycle per transfer.

## Configuration
- APB_SLV_PSLVERR_EN defined:
  - a write to addr>=RO_BASE raises PSLVERR together with PREADY;
  - the memory is not updated;
  - reads of that region are legal and PSLVERR=0.
  - Memory entries in the read-only region are still reset to 8'h00.
- APB_SLV_PSLVERR_EN not defined:
  - PSLVERR is tied to 0;
  - all 256 addresses are writable;
  - RO_BASE is unused.

## Test plan
- Reset then idle: PRESETn low for 3 cycles -> PRDATA=8'h00, PREADY=0, PSLVERR=0; a read of addr 8'h10 returns 8'h00.
- WAIT_STATES=0, write 8'hA5 to 9'h012, then read 9'h012 -> each PREADY arrives the cycle after setup; the read returns PRDATA=8'hA5.
- WAIT_STATES=3, read 9'h112 after writing 8'h3C -> PREADY rises 4 cycles after setup; PRDATA=8'h3C; bit 8 is ignored.
- Abort: WAIT_STATES=2, write 8'hFF to 8'h20, PSEL dropped in the first access cycle -> no PREADY pulse; a later read of 8'h20 returns the old value.
- APB_SLV_PSLVERR_EN defined, write 8'h55 to 8'hF4 -> PREADY=1 with PSLVERR=1; a read of 8'hF4 returns 8'h00 with PSLVERR=0. Without the macro, the same read returns 8'h55.
- Back-to-back: bridge issues write 8'h11 @8'h01 followed immediately by a read @8'h01 with transfer held high -> both complete, no idle gap beyond the setup cycle, read returns 8'h11.
